// File: rtl/q1_sym_feeder_if.sv
// q1_sym_feeder_if: host/feeder bundle for the q1 symbol feeder
// Ports: wr_data/wr_valid/wr_ready enqueue channel, start/pause playout
// control, sym/sym_valid/busy/count playout status.
interface q1_sym_feeder_if #(
  parameter int DEPTH = 8,
  parameter int W = 2
);
  logic [W-1:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic start;
  logic pause;
  logic [W-1:0] sym;
  logic sym_valid;
  logic busy;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output wr_data, wr_valid, start, pause,
    input wr_ready, sym, sym_valid, busy, count
  );
  modport slave (
    input wr_data, wr_valid, start, pause,
    output wr_ready, sym, sym_valid, busy, count
  );
endinterface

// File: rtl/q1_sym_feeder.sv
// q1_sym_feeder: queues 2-bit codes and replays them one per clock onto q1 `in`
// Ports: clk, reset (sync, active-high), f (q1_sym_feeder_if.slave).
// Optional: define Q1_SYM_FEEDER_LOOP_EN for cyclic loop playout.
module q1_sym_feeder #(
  parameter int DEPTH = 8,
  parameter int W = 2,
  parameter logic [W-1:0] IDLE_SYM = '0
) (
  input logic clk,
  input logic reset,
  q1_sym_feeder_if.slave f
);
  localparam int AW = $clog2(DEPTH);
`ifdef Q1_SYM_FEEDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_nx;
  logic push, pop, wr_en;
  logic [W-1:0] wr_word;
  // In loop mode writes are locked out while running, and a start in RUN
  // stops playout on that edge without popping.
  assign f.wr_ready = (f.count < (AW+1)'(DEPTH)) && !(LOOP && state == RUN);
  assign f.busy = (state == RUN);
  assign push = f.wr_valid && f.wr_ready;
  assign pop = (state == RUN) && !f.pause && (f.count != 0) && !(LOOP && f.start);
  // Loop mode recirculates the popped head to the tail, so occupancy holds.
  assign wr_en = push || (LOOP && pop);
  assign wr_word = push ? f.wr_data : mem[rd_ptr];
  assign count_nx = f.count + (AW+1)'(push) - (AW+1)'(pop && !LOOP);
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (f.start && f.count != 0) ? RUN : IDLE;
    else
      state_nx = (count_nx == 0 || (LOOP && f.start)) ? IDLE : RUN;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      f.count <= '0;
      f.sym <= IDLE_SYM;
      f.sym_valid <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      f.count <= count_nx;
      f.sym <= pop ? mem[rd_ptr] : IDLE_SYM;
      f.sym_valid <= pop;
    end
  end
endmodule

// File: tb/tb_q1_sym_feeder.sv
// tb_q1_sym_feeder: scoreboard bench for q1_sym_feeder
module tb_q1_sym_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit live = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];
  q1_sym_feeder_if #(.DEPTH(8), .W(2)) f();
  q1_sym_feeder #(.DEPTH(8), .W(2), .IDLE_SYM(2'b00)) dut (.clk(clk), .reset(reset), .f(f));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] d, input bit track);
    f.wr_valid = 1'b1;
    f.wr_data = d;
    tick();
    f.wr_valid = 1'b0;
    if (track) exp_q.push_back(d);
  endtask
  task automatic pulse_start;
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
  endtask
  always @(negedge clk) begin
    if (live) begin
      if (f.sym_valid) begin
        if (exp_q.size() == 0) chk("unexpected_sym", int'(f.sym), -1);
        else chk("sym", int'(f.sym), int'(exp_q.pop_front()));
      end else chk("idle_sym", int'(f.sym), 0);
    end
  end
  initial begin
    logic [1:0] v4 [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    logic [1:0] v8 [8] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
    f.wr_valid = 1'b0;
    f.wr_data = 2'b00;
    f.start = 1'b0;
    f.pause = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    live = 1'b1;
    chk("rst_count", int'(f.count), 0);
    chk("rst_wr_ready", int'(f.wr_ready), 1);
    chk("rst_busy", int'(f.busy), 0);
    chk("rst_sym_valid", int'(f.sym_valid), 0);
    chk("rst_sym", int'(f.sym), 0);
`ifdef Q1_SYM_FEEDER_LOOP_EN
    push(2'b01, 1'b0);
    push(2'b10, 1'b0);
    pulse_start();
    chk("loop_busy", int'(f.busy), 1);
    for (int i = 0; i < 6; i++) exp_q.push_back(i[0] ? 2'b10 : 2'b01);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("loop_count", int'(f.count), 2);
      chk("loop_wr_ready", int'(f.wr_ready), 0);
    end
    pulse_start();
    chk("loop_stop_busy", int'(f.busy), 0);
    chk("loop_stop_valid", int'(f.sym_valid), 0);
    chk("loop_stop_count", int'(f.count), 2);
    pulse_start();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    tick();
    tick();
    pulse_start();
    chk("loop_stop2_busy", int'(f.busy), 0);
`else
    foreach (v4[i]) push(v4[i], 1'b1);
    chk("t1_count", int'(f.count), 4);
    pulse_start();
    chk("t1_busy_run", int'(f.busy), 1);
    chk("t1_no_sym_yet", int'(f.sym_valid), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t1_busy_before_last", int'(f.busy), 1);
    tick();
    chk("t1_busy_drop", int'(f.busy), 0);
    chk("t1_count_end", int'(f.count), 0);
    tick();
    chk("t1_valid_after", int'(f.sym_valid), 0);
    foreach (v8[i]) push(v8[i], 1'b1);
    chk("t2_wr_ready_full", int'(f.wr_ready), 0);
    chk("t2_count_full", int'(f.count), 8);
    push(2'b11, 1'b0);
    chk("t2_count_drop", int'(f.count), 8);
    pulse_start();
    for (int i = 0; i < 9; i++) tick();
    chk("t2_busy_end", int'(f.busy), 0);
    chk("t2_count_end", int'(f.count), 0);
    foreach (v4[i]) push(v4[i], 1'b1);
    pulse_start();
    tick();
    f.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_pause_valid", int'(f.sym_valid), 0);
      chk("t3_pause_count", int'(f.count), 3);
    end
    f.pause = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_busy_end", int'(f.busy), 0);
    pulse_start();
    chk("t4_empty_start", int'(f.busy), 0);
    f.start = 1'b1;
    push(2'b11, 1'b1);
    f.start = 1'b0;
    chk("t4_push_start_busy", int'(f.busy), 0);
    chk("t4_push_start_count", int'(f.count), 1);
    pulse_start();
    chk("t4_run", int'(f.busy), 1);
    tick();
    chk("t4_end", int'(f.busy), 0);
    push(2'b01, 1'b1);
    push(2'b10, 1'b1);
    push(2'b11, 1'b1);
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_count", int'(f.count), 0);
    chk("t5_valid", int'(f.sym_valid), 0);
    chk("t5_busy", int'(f.busy), 0);
    chk("t5_sym", int'(f.sym), 0);
    exp_q.delete();
    reset = 1'b0;
    pulse_start();
    chk("t5_start_ignored", int'(f.busy), 0);
`endif
    for (int i = 0; i < 4; i++) tick();
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
